// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle RV32I-subset controller.
// Holds the state encoding, opcode constants, ALU/imm control codes, mux
// select encodings, the bundled control-output struct and the imm decoder.
package multicycle_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned IMM_W   = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL_S     = 4'd10,
    S_JALR_ADR  = 4'd11,
    S_JALR_LINK = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LOAD    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_CUSTOM0 = 7'b0001011;
  localparam logic [OP_W-1:0] OP_ITYPE   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL     = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR    = 7'b1100111;

  localparam logic [F7_W-1:0] F7_SUB = 7'b0100000;

  // ALU control codes
  localparam logic [ALU_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND   = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SRL   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_ADD_V = 3'b100;
  localparam logic [ALU_W-1:0] ALU_AVG_V = 3'b101;

  // Immediate format codes
  localparam logic [IMM_W-1:0] IMM_NONE = 3'b000;
  localparam logic [IMM_W-1:0] IMM_I    = 3'b001;
  localparam logic [IMM_W-1:0] IMM_S    = 3'b010;
  localparam logic [IMM_W-1:0] IMM_B    = 3'b011;
  localparam logic [IMM_W-1:0] IMM_J    = 3'b101;

  // Mux selects
  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_RS2    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [SEL_W-1:0] RES_ALUOUT   = 2'b00;
  localparam logic [SEL_W-1:0] RES_MDR      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU      = 2'b10;
  localparam logic             ADR_PC       = 1'b0;
  localparam logic             ADR_ALUOUT   = 1'b1;

  // Every datapath control driven by the controller
  typedef struct packed {
    logic             mem_req;
    logic             mem_we;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] result_src;
    logic [ALU_W-1:0] alu_control;
    logic [IMM_W-1:0] imm_control;
    logic             retire;
    logic             illegal;
  } ctrl_t;

  // Immediate format implied by the opcode
  function automatic logic [IMM_W-1:0] imm_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: return IMM_I;
      OP_STORE:                   return IMM_S;
      OP_BRANCH:                  return IMM_B;
      OP_JAL:                     return IMM_J;
      default:                    return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset (plus vector ops) controller.
// Sequences fetch/decode/execute/memory/writeback over one shared memory
// port (mem_req/mem_ready) and drives all datapath selects and strobes.
// Ports: clk, reset (async, active-high); IR fields opcode/funct3/funct7;
// alu_zero; mem_ready; outputs mem_req, mem_we, adr_src, ir_write,
// pc_write, reg_write, alu_src_a/b, result_src, alu_control, imm_control,
// retire (one pulse per completed instruction), illegal (in HALT).
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic [F3_W-1:0]  funct3,
  input  logic [F7_W-1:0]  funct7,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [SEL_W-1:0] alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] result_src,
  output logic [ALU_W-1:0] alu_control,
  output logic [IMM_W-1:0] imm_control,
  output logic             retire,
  output logic             illegal
);

  // The PC register owns the reset vector; kept here for documentation only.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  state_t state, state_next;
  ctrl_t  ctrl;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next state and control outputs
  always_comb begin
    state_next = state;
    ctrl       = '0;
    if (state != S_FETCH) ctrl.imm_control = imm_sel(opcode);

    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch/jump target: ALUOut <= oldPC + imm
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE:    state_next = S_MEM_ADR;
          OP_RTYPE, OP_CUSTOM0: state_next = S_EXEC_R;
          OP_ITYPE:             state_next = S_EXEC_I;
          OP_BRANCH:            state_next = (funct3 == 3'b000) ? S_BRANCH : S_HALT;
          OP_JAL:               state_next = S_JAL_S;
          OP_JALR:              state_next = S_JALR_ADR;
          default:              state_next = S_HALT;
        endcase
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_next     = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = ADR_ALUOUT;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.result_src = RES_MDR;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = ADR_ALUOUT;
        ctrl.retire  = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        state_next     = S_ALU_WB;
        if (opcode == OP_CUSTOM0) begin
          case (funct3)
            3'b000:  ctrl.alu_control = ALU_ADD_V;
            3'b001:  ctrl.alu_control = ALU_AVG_V;
            default: state_next = S_HALT;
          endcase
        end else begin
          case (funct3)
            3'b000:  ctrl.alu_control = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
            3'b111:  ctrl.alu_control = ALU_AND;
            3'b101:  ctrl.alu_control = ALU_SRL;
            default: state_next = S_HALT;
          endcase
        end
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_next     = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        state_next      = S_FETCH;
      end
      S_BRANCH: begin
        // Taken target was computed in DECODE and sits in ALUOut
        ctrl.alu_src_a   = SRC_A_RS1;
        ctrl.alu_src_b   = SRC_B_RS2;
        ctrl.alu_control = ALU_SUB;
        ctrl.result_src  = RES_ALUOUT;
        ctrl.pc_write    = alu_zero;
        ctrl.retire      = 1'b1;
        state_next       = S_FETCH;
      end
      S_JAL_S: begin
        // PC <= target from DECODE while ALU forms the link value oldPC + 4
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_a  = SRC_A_OLD_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        state_next      = S_ALU_WB;
      end
      S_JALR_ADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_next     = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_a  = SRC_A_OLD_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        state_next      = S_ALU_WB;
      end
      S_HALT: begin
        ctrl.illegal = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset silences every output immediately, including a pending access
    if (reset) ctrl = '0;
  end

  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign adr_src     = ctrl.adr_src;
  assign ir_write    = ctrl.ir_write;
  assign pc_write    = ctrl.pc_write;
  assign reg_write   = ctrl.reg_write;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign result_src  = ctrl.result_src;
  assign alu_control = ctrl.alu_control;
  assign imm_control = ctrl.imm_control;
  assign retire      = ctrl.retire;
  assign illegal     = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per instruction class it builds
// the expected sequence of phases and checks every output on every cycle,
// plus retire count and instruction latency against the latency table.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero, mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control, imm_control;
  logic       retire, illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .imm_control(imm_control), .retire(retire), .illegal(illegal)
  );

  typedef struct packed {
    logic       req, we, adr, irw, pcw, rw;
    logic [1:0] a, b, rs;
    logic [2:0] alu, imm;
    logic       ret, ill;
  } outv_t;

  typedef struct {
    outv_t e;
    bit    mem;   // waits on mem_ready; strobes gated by it
    bit    br;    // pc_write follows alu_zero
    string name;
  } step_t;

  // Instruction classes
  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_ILL_DEC = 7, C_ILL_EX = 8;

  step_t q[$];

  function automatic outv_t mk(bit req, bit we, bit adr, bit irw, bit pcw, bit rw,
                               logic [1:0] a, logic [1:0] b, logic [1:0] rs,
                               logic [2:0] alu, logic [2:0] imm, bit ret, bit ill);
    outv_t o;
    o.req = req; o.we = we; o.adr = adr; o.irw = irw; o.pcw = pcw; o.rw = rw;
    o.a = a; o.b = b; o.rs = rs; o.alu = alu; o.imm = imm; o.ret = ret; o.ill = ill;
    return o;
  endfunction

  function automatic outv_t sample();
    outv_t o;
    o.req = mem_req; o.we = mem_we; o.adr = adr_src; o.irw = ir_write; o.pcw = pc_write;
    o.rw = reg_write; o.a = alu_src_a; o.b = alu_src_b; o.rs = result_src;
    o.alu = alu_control; o.imm = imm_control; o.ret = retire; o.ill = illegal;
    return o;
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b001;
      7'b0100011: return 3'b010;
      7'b1100011: return 3'b011;
      7'b1101111: return 3'b101;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic int classify(logic [6:0] op, logic [2:0] f3);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0010011: return C_I;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b1100011: return (f3 == 3'b000) ? C_BR : C_ILL_DEC;
      7'b0110011: return (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b101) ? C_R : C_ILL_EX;
      7'b0001011: return (f3 <= 3'b001) ? C_R : C_ILL_EX;
      default:    return C_ILL_DEC;
    endcase
  endfunction

  // ALU operation an R-format instruction should request
  function automatic logic [2:0] r_alu(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    if (op == 7'b0001011) return (f3 == 3'b000) ? 3'b100 : 3'b101;
    case (f3)
      3'b111:  return 3'b010;
      3'b101:  return 3'b011;
      default: return (f7 == 7'b0100000) ? 3'b001 : 3'b000;
    endcase
  endfunction

  task automatic add_step(input outv_t e, input bit mem, input bit br, input string name);
    step_t s;
    s.e = e; s.mem = mem; s.br = br; s.name = name;
    q.push_back(s);
  endtask

  task automatic check(input string tag, input outv_t exp);
    outv_t obs;
    obs = sample();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH. wf/wm: mem_ready wait cycles for the
  // fetch and data access (-1 = random); zmode: alu_zero value (-1 = random).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int wf, input int wm, input int zmode, input string tag);
    int    cls, nw, cyc, ret_cnt, ret_cyc, waits;
    int    base_lat[7] = '{5, 4, 4, 4, 3, 4, 5};
    logic [2:0] imm;
    outv_t e, wb;
    opcode = op; funct3 = f3; funct7 = f7;
    imm = imm_of(op);
    cls = classify(op, f3);
    q.delete();
    wb = mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, imm, 1, 0);
    add_step(mk(1,0,0,1,1,0, 2'b00,2'b10,2'b10, 3'b000, 3'b000, 0, 0), 1, 0, "fetch");
    add_step(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b000, imm, 0, 0), 0, 0, "decode");
    case (cls)
      C_LOAD: begin
        add_step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, imm, 0, 0), 0, 0, "mem_adr");
        add_step(mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, imm, 0, 0), 1, 0, "mem_rd");
        add_step(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b01, 3'b000, imm, 1, 0), 0, 0, "mem_wb");
      end
      C_STORE: begin
        add_step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, imm, 0, 0), 0, 0, "mem_adr");
        add_step(mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, imm, 1, 0), 1, 0, "mem_wr");
      end
      C_R: begin
        add_step(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00, r_alu(op, f3, f7), imm, 0, 0), 0, 0, "exec_r");
        add_step(wb, 0, 0, "alu_wb");
      end
      C_I: begin
        add_step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, imm, 0, 0), 0, 0, "exec_i");
        add_step(wb, 0, 0, "alu_wb");
      end
      C_BR:
        add_step(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, imm, 1, 0), 0, 1, "branch");
      C_JAL: begin
        add_step(mk(0,0,0,0,1,0, 2'b01,2'b10,2'b00, 3'b000, imm, 0, 0), 0, 0, "jal");
        add_step(wb, 0, 0, "alu_wb");
      end
      C_JALR: begin
        add_step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, imm, 0, 0), 0, 0, "jalr_adr");
        add_step(mk(0,0,0,0,1,0, 2'b01,2'b10,2'b00, 3'b000, imm, 0, 0), 0, 0, "jalr_link");
        add_step(wb, 0, 0, "alu_wb");
      end
      default: begin
        if (cls == C_ILL_EX)
          add_step(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b000, imm, 0, 0), 0, 0, "exec_r");
        for (int h = 0; h < 20; h++)
          add_step(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, imm, 0, 1), 0, 0, "halt");
      end
    endcase

    cyc = 0; ret_cnt = 0; ret_cyc = -1; waits = 0;
    foreach (q[i]) begin
      nw = 0;
      if (q[i].mem) begin
        nw = (i == 0) ? wf : wm;
        if (nw < 0) nw = int'($urandom_range(0, 3));
      end
      waits += nw;
      for (int w = 0; w <= nw; w++) begin
        mem_ready = q[i].mem ? (w == nw) : 1'($urandom);
        alu_zero  = (zmode < 0) ? 1'($urandom) : 1'(zmode);
        e = q[i].e;
        if (q[i].br) e.pcw = alu_zero;
        if (q[i].mem && !mem_ready) begin
          e.irw = 1'b0; e.pcw = 1'b0; e.rw = 1'b0; e.ret = 1'b0;
        end
        #1;
        cyc++;
        check($sformatf("%s.%s.c%0d", tag, q[i].name, cyc), e);
        if (retire) begin
          ret_cnt++;
          ret_cyc = cyc;
        end
        @(negedge clk);
      end
    end
    if (cls <= C_JALR) begin
      check_int({tag, ".retire_count"}, ret_cnt, 1);
      check_int({tag, ".latency"}, ret_cyc, base_lat[cls] + waits);
    end else begin
      check_int({tag, ".retire_count"}, ret_cnt, 0);
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, ".in_reset"}, '0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int         cls;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [2:0] r3[3] = '{3'b000, 3'b111, 3'b101};

    reset = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; alu_zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset.t0", '0);
    @(negedge clk);
    check("reset.held", '0);
    @(negedge clk);
    reset = 1'b0;

    // Directed scenarios
    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, -1, "add_x3");
    run_instr(7'b0000011, 3'b010, 7'b0000000, 3, 2, -1, "lw_x5");
    run_instr(7'b1100011, 3'b000, 7'b0000000, 0, 0,  1, "beq_taken");
    run_instr(7'b1100011, 3'b000, 7'b0000000, 0, 0,  0, "beq_not");
    run_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0, -1, "jal");
    run_instr(7'b1100111, 3'b000, 7'b0000000, 1, 0, -1, "jalr");
    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, -1, "sub");
    run_instr(7'b0001011, 3'b001, 7'b0000000, 0, 0, -1, "avg_v");
    run_instr(7'b0100011, 3'b010, 7'b0000000, 2, 3, -1, "sw");
    run_instr(7'b0001011, 3'b010, 7'b0000000, 0, 0, -1, "custom_bad");
    apply_reset("after_custom_bad");
    run_instr(7'b1100011, 3'b001, 7'b0000000, 0, 0, -1, "bne_halt");
    apply_reset("after_bne");
    run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0, -1, "bad_opcode");
    apply_reset("after_bad_op");

    // Reset in the middle of a stalled store
    opcode = 7'b0100011; funct3 = 3'b010; funct7 = '0; mem_ready = 1'b1; alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("rst_mid_wr.wait", mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 3'b010, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_wr.assert", '0);
    @(negedge clk);
    #1;
    check("rst_mid_wr.held", '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_wr.release", mk(1,0,0,0,0,0, 2'b00,2'b10,2'b10, 3'b000, 3'b000, 0, 0));
    @(negedge clk);

    // Randomized legal instruction stream
    for (int n = 0; n < 150; n++) begin
      cls = int'($urandom_range(0, 6));
      f3 = 3'($urandom);
      f7 = 7'b0000000;
      case (cls)
        C_LOAD:  op = 7'b0000011;
        C_STORE: op = 7'b0100011;
        C_I:     op = 7'b0010011;
        C_BR:    begin op = 7'b1100011; f3 = 3'b000; end
        C_JAL:   op = 7'b1101111;
        C_JALR:  op = 7'b1100111;
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            op = 7'b0110011;
            f3 = r3[$urandom_range(0, 2)];
            f7 = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'b0000000;
          end else begin
            op = 7'b0001011;
            f3 = 3'($urandom_range(0, 1));
          end
        end
      endcase
      run_instr(op, f3, f7, -1, -1, -1, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
